// File: rtl/cdm_pkg.sv
// Shared types and constants for the CDM16 sequential multiplier controller.
package cdm_pkg;

  localparam int LANE_W    = 8;
  localparam int PROD_W    = 16;
  localparam int NUM_LANES = 4;

  // One state per partial product, plus idle and result-hold.
  typedef enum logic [2:0] {
    IDLE,
    LL,
    HL,
    LH,
    HH,
    DONE
  } state_t;

  // Lowest byte lane that the current partial product lands in.
  // The product's low byte goes to that lane and its high byte to the next lane up.
  function automatic logic [1:0] lane_base(input state_t s);
    case (s)
      HL, LH:  lane_base = 2'd1;
      HH:      lane_base = 2'd2;
      default: lane_base = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/Arraymul_eight_eight.sv
// Exact 8x8 array multiplier built as a sum of shifted partial-product rows.
module Arraymul_eight_eight
  import cdm_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  // Add one shifted copy of a for every set bit of b.
  always_comb begin
    p = '0;
    for (int i = 0; i < LANE_W; i++) begin
      if (b[i]) p = p + ({{(PROD_W-LANE_W){1'b0}}, a} << i);
    end
  end

endmodule

// File: rtl/adder8_8.sv
// Byte-lane adder: the sum wraps modulo 256 and there is no carry-out.
module adder8_8
  import cdm_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] s
);

  assign s = a + b;

endmodule

// File: rtl/cdm16_lane_acc.sv
// Four independent byte-lane accumulators. Each product is added into lanes
// base and base+1. Lanes never exchange carries.
module cdm16_lane_acc
  import cdm_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 acc_en,
  input  logic [1:0]                           base,
  input  logic [PROD_W-1:0]                    p,
  output logic [NUM_LANES-1:0][LANE_W-1:0]     lanes
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_q, addend, sum;

  // Lanes start at zero after clr. L0 and L3 therefore only ever receive a
  // single product byte, so their "load" is the same as an add to zero.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [2:0] IDX = 3'(gi);
    assign addend[gi] = ({1'b0, base} == IDX)         ? p[LANE_W-1:0]      :
                        ({1'b0, base} + 3'd1 == IDX)  ? p[PROD_W-1:LANE_W] :
                                                        '0;
    adder8_8 u_add (.a(lane_q[gi]), .b(addend[gi]), .s(sum[gi]));
  end

  // Lane registers: clear on accept, accumulate during product cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lane_q <= '0;
    else if (clr)    lane_q <= '0;
    else if (acc_en) lane_q <= sum;
  end

  assign lanes = lane_q;

endmodule

// File: rtl/cdm8_40.sv
// Approximate 8x8 multiplier. It forms four exact 4x4 nibble products and
// accumulates them into 4-bit lanes. Any carry out of a nibble lane is dropped,
// which is the same carry-disregard scheme applied one level down.
module cdm8_40
  import cdm_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [7:0] pll, phl, plh, phh;
  logic [3:0] n0, n1, n2, n3;

  assign pll = {4'b0, a[3:0]} * {4'b0, b[3:0]};
  assign phl = {4'b0, a[7:4]} * {4'b0, b[3:0]};
  assign plh = {4'b0, a[3:0]} * {4'b0, b[7:4]};
  assign phh = {4'b0, a[7:4]} * {4'b0, b[7:4]};

  assign n0 = pll[3:0];
  assign n1 = pll[7:4] + phl[3:0] + plh[3:0];
  assign n2 = phl[7:4] + plh[7:4] + phh[3:0];
  assign n3 = phh[7:4];

  assign p = {n3, n2, n1, n0};

endmodule

// File: rtl/cdm16_seq_ctrl.sv
// CDM16 sequential controller. Issues one 8x8 partial product per clock into
// byte-lane accumulators and drops inter-lane carries. Valid/ready on both sides.
module cdm16_seq_ctrl
  import cdm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      R,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  state_t                           state;
  logic [15:0]                      a_q, b_q;
  logic [LANE_W-1:0]                mul_a, mul_b;
  logic [PROD_W-1:0]                p_cdm, p_mul, p_sel;
  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  logic                             acc_en, clr;

  // The LL product uses the approximate unit, which sees only the low bytes.
  cdm8_40 u_cdm (.a(a_q[7:0]), .b(b_q[7:0]), .p(p_cdm));

  // Select the byte pair that the shared exact multiplier works on in this state.
  always_comb begin
    mul_a = a_q[15:8];
    mul_b = b_q[7:0];
    case (state)
      LH:      begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
      HH:      begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
      default: ;
    endcase
  end

  Arraymul_eight_eight u_mul (.a(mul_a), .b(mul_b), .p(p_mul));

  assign p_sel  = (state == LL) ? p_cdm : p_mul;
  assign acc_en = (state == LL) || (state == HL) || (state == LH) || (state == HH);
  assign clr    = (state == IDLE) && in_valid && in_ready;

  cdm16_lane_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .acc_en (acc_en),
    .base   (lane_base(state)),
    .p      (p_sel),
    .lanes  (lanes)
  );

  // R comes straight from the lane registers, so it stays stable while in DONE.
  assign R = lanes;

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_cnt    <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_q      <= A;
          b_q      <= B;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= LL;
        end
        LL: state <= HL;
        HL: state <= LH;
        LH: state <= HH;
        HH: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          op_cnt    <= op_cnt + CNT_W'(1);
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdm16_seq_ctrl.sv
// Directed bench for cdm16_seq_ctrl: vector table plus reset, stall and stream sequences.
module tb_cdm16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] R;
  logic [15:0] op_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  cdm16_seq_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One operation with out_ready low until the result shows, then a single accept.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string nm);
    logic [15:0] cnt0;
    int k;
    @(negedge clk);
    cnt0 = op_cnt;
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom);   // operands must already be captured
    chk({nm, " in_ready_busy"}, {in_ready, busy}, 2'b01);
    k = 1;
    @(posedge clk); #1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, k, 4);
    chk({nm, " R"}, R, exp);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " exit"}, {out_valid, in_ready, busy}, 3'b010);
    chk({nm, " op_cnt"}, op_cnt, cnt0 + 16'd1);
  endtask

  initial begin
    int   idx, nres, stray;
    int   t_res[8];
    logic [31:0] r_res[8];
    logic [15:0] cnt0;

    vecs[0] = '{16'h0100, 16'h0100, 32'h0001_0000};
    vecs[1] = '{16'hFF00, 16'hFF00, 32'hFE01_0000};
    vecs[2] = '{16'hFFFF, 16'hFF00, 32'hFEFF_0100};
    vecs[3] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[4] = '{16'h0200, 16'h0080, 32'h0001_0000};
    vecs[5] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
    vecs[6] = '{16'h8000, 16'h8080, 32'h4040_0000};
    vecs[7] = '{16'hFF01, 16'h01FF, 32'h00FD_02FF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {in_ready, out_valid, busy}, 3'b100);
    chk("reset R", R, 32'h0);
    chk("reset op_cnt", op_cnt, 16'h0);
    @(negedge clk); rst = 1'b0;

    // Reset in the LH cycle of an operation discards it
    @(negedge clk); A = 16'hFFFF; B = 16'hFF00; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("midop busy", busy, 1'b1);
    rst = 1'b1; #1;
    chk("midop rst outs", {in_ready, out_valid, busy}, 3'b100);
    chk("midop rst R", R, 32'h0);
    chk("midop rst op_cnt", op_cnt, 16'h0);
    @(negedge clk); rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid || busy) stray++;
    end
    chk("midop no result", stray, 0);

    // Vector table, one op at a time
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Stall in DONE with ignored in_valid pulses
    @(negedge clk); A = 16'hFF00; B = 16'hFF00; in_valid = 1'b1;
    cnt0 = op_cnt;
    @(posedge clk); #1; in_valid = 1'b0;
    idx = 0;
    while (!out_valid && idx < 20) begin
      @(posedge clk); #1;
      idx++;
    end
    chk("stall reached", out_valid, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      chk($sformatf("stall c%0d outs", c), {out_valid, in_ready, busy}, 3'b101);
      chk($sformatf("stall c%0d R", c), R, 32'hFE01_0000);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("stall exit outs", {out_valid, in_ready, busy}, 3'b010);
    chk("stall exit op_cnt", op_cnt, cnt0 + 16'd1);

    // Back-to-back stream of four ops
    cnt0 = op_cnt;
    idx = 0; nres = 0;
    @(negedge clk); out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ready) begin
        if (idx < 4) begin
          A = vecs[idx].a; B = vecs[idx].b; in_valid = 1'b1; idx++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        A = 16'($urandom); B = 16'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid && nres < 8) begin
        t_res[nres] = c; r_res[nres] = R; nres++;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk("stream count", nres, 4);
    chk("stream first latency", t_res[0], 4);
    for (int i = 0; i < 4 && i < nres; i++) begin
      chk($sformatf("stream R%0d", i), r_res[i], vecs[i].r);
      if (i > 0) chk($sformatf("stream gap%0d", i), t_res[i] - t_res[i-1], 6);
    end
    chk("stream op_cnt", op_cnt, cnt0 + 16'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
